// File: rtl/protocore_pkg.sv
// ProtoCore shared definitions: opcode constants, instruction field positions
// and the control-unit state encoding.
package protocore_pkg;

    // Instruction field bit positions inside the 16-bit instruction word
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 4;
    localparam int RB_MSB  = 3;
    localparam int RB_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes 0x0-0x7 are ALU operations; the rest are listed here
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_NOP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Sequential program-counter successor; wraps 8'hFF -> 8'h00
    function automatic logic [7:0] pc_next(input logic [7:0] pc);
        return pc + 8'h01;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction classifier for the ProtoCore control unit.
module cu_decode
    import protocore_pkg::*;
(
    input  logic [15:0] ir,
    input  logic        flag_z,
    input  logic        flag_c,
    output logic        is_alu,
    output logic        is_ldi,
    output logic        is_branch,
    output logic        branch_taken,
    output logic        is_halt,
    output logic        is_illegal
);

    logic [3:0] op_s;

    assign op_s = ir[OP_MSB:OP_LSB];

    // Classify the opcode and resolve conditional branches against the latched flags
    always_comb begin
        is_alu       = 1'b0;
        is_ldi       = 1'b0;
        is_branch    = 1'b0;
        branch_taken = 1'b0;
        is_halt      = 1'b0;
        is_illegal   = 1'b0;
        if (op_s[3] == 1'b0) begin
            is_alu = 1'b1;
        end else begin
            case (op_s)
                OP_LDI: begin
                    is_ldi = 1'b1;
                end
                OP_JMP: begin
                    is_branch    = 1'b1;
                    branch_taken = 1'b1;
                end
                OP_JZ: begin
                    is_branch    = 1'b1;
                    branch_taken = flag_z;
                end
                OP_JC: begin
                    is_branch    = 1'b1;
                    branch_taken = flag_c;
                end
                OP_NOP: begin
                    is_branch = 1'b0;
                end
                OP_HALT: begin
                    is_halt = 1'b1;
                end
                default: begin
                    // 0xD and 0xE are unassigned
                    is_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// ProtoCore fetch/decode/execute sequencer. Every datapath control output is
// a register so the datapath's synchronous write sees glitch-free values.
module control_unit
    import protocore_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [2:0]  alu_opcode,
    output logic [3:0]  ra_addr,
    output logic [3:0]  rb_addr,
    output logic [3:0]  write_addr,
    output logic [7:0]  write_data,
    output logic        imm_sel,
    output logic        write_en,
    input  logic        alu_zero,
    input  logic        alu_carry,
    output logic [7:0]  pc,
    output logic        flag_z,
    output logic        flag_c,
    output logic        halted,
    output logic        illegal
);

    state_t      state_r;
    logic [15:0] ir_r;
    logic [7:0]  pc_r;
    logic        imem_req_r;
    logic [2:0]  alu_opcode_r;
    logic [3:0]  ra_addr_r;
    logic [3:0]  rb_addr_r;
    logic [3:0]  write_addr_r;
    logic [7:0]  write_data_r;
    logic        imm_sel_r;
    logic        write_en_r;
    logic        flag_z_r;
    logic        flag_c_r;
    logic        halted_r;
    logic        illegal_r;

    logic is_alu_s;
    logic is_ldi_s;
    logic is_branch_s;
    logic branch_taken_s;
    logic is_halt_s;
    logic is_illegal_s;

    cu_decode u_decode (
        .ir           (ir_r),
        .flag_z       (flag_z_r),
        .flag_c       (flag_c_r),
        .is_alu       (is_alu_s),
        .is_ldi       (is_ldi_s),
        .is_branch    (is_branch_s),
        .branch_taken (branch_taken_s),
        .is_halt      (is_halt_s),
        .is_illegal   (is_illegal_s)
    );

    assign imem_req   = imem_req_r;
    assign imem_addr  = pc_r;
    assign alu_opcode = alu_opcode_r;
    assign ra_addr    = ra_addr_r;
    assign rb_addr    = rb_addr_r;
    assign write_addr = write_addr_r;
    assign write_data = write_data_r;
    assign imm_sel    = imm_sel_r;
    assign write_en   = write_en_r;
    assign pc         = pc_r;
    assign flag_z     = flag_z_r;
    assign flag_c     = flag_c_r;
    assign halted     = halted_r;
    assign illegal    = illegal_r;

    // Sequencer FSM: owns state, ir, pc, flags and every registered control output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ir_r         <= 16'h0000;
            pc_r         <= RESET_PC;
            imem_req_r   <= 1'b0;
            alu_opcode_r <= 3'd0;
            ra_addr_r    <= 4'd0;
            rb_addr_r    <= 4'd0;
            write_addr_r <= 4'd0;
            write_data_r <= 8'h00;
            imm_sel_r    <= 1'b0;
            write_en_r   <= 1'b0;
            flag_z_r     <= 1'b0;
            flag_c_r     <= 1'b0;
            halted_r     <= 1'b0;
            illegal_r    <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse raised only on entry to EXEC
            write_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_FETCH;
                    imem_req_r <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_valid) begin
                        // Fields are loaded from the incoming word so they are
                        // already stable throughout DECODE and EXEC
                        ir_r         <= imem_data;
                        alu_opcode_r <= imem_data[OP_LSB+2:OP_LSB];
                        ra_addr_r    <= imem_data[RA_MSB:RA_LSB];
                        rb_addr_r    <= imem_data[RB_MSB:RB_LSB];
                        write_addr_r <= imem_data[RD_MSB:RD_LSB];
                        write_data_r <= imem_data[IMM_MSB:IMM_LSB];
                        imm_sel_r    <= (imem_data[OP_MSB:OP_LSB] == OP_LDI);
                        imem_req_r   <= 1'b0;
                        state_r      <= ST_DECODE;
                    end else begin
                        imem_req_r <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    write_en_r <= is_alu_s | is_ldi_s;
                    state_r    <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_alu_s) begin
                        flag_z_r <= alu_zero;
                        flag_c_r <= alu_carry;
                    end else begin
                        flag_z_r <= flag_z_r;
                        flag_c_r <= flag_c_r;
                    end
                    if (is_halt_s | is_illegal_s) begin
                        // pc stays at the stopping instruction's address
                        halted_r  <= 1'b1;
                        illegal_r <= illegal_r | is_illegal_s;
                        state_r   <= ST_HALT;
                    end else begin
                        if (is_branch_s && branch_taken_s) begin
                            pc_r <= ir_r[IMM_MSB:IMM_LSB];
                        end else begin
                            pc_r <= pc_next(pc_r);
                        end
                        imem_req_r <= 1'b1;
                        state_r    <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    imem_req_r <= 1'b0;
                    halted_r   <= 1'b1;
                end
                default: begin
                    imem_req_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
